dm_scroller: RTL and testbench
==============================

# dm_scroller

Column-buffer text scroller that generates the 64-bit frame image for the 8x8 dot-matrix scanner. A host writes message columns into an internal buffer; the block builds an 8-column window, presents it on `o_Data` in the scanner's row-major format, and advances the window one column every `i_Speed+1` frames. Window updates happen only on the scanner's end-of-frame pulse, so a scanned frame never mixes two windows.

## Interface
- `MSG_LEN`, 32: message length in columns; legal range 9..256.
- `ADDR_W`, 5: buffer address width; must satisfy 2^ADDR_W >= MSG_LEN.

- `i_Clk`  in  1  system clock, 50 MHz.
- `i_Rst`  in  1  reset; one clock, asynchronous, active-low.
- `i_fFrame`  in  1  one-cycle end-of-frame pulse from the scanner's done output.
- `i_Run`  in  1  level; 1 = scroll, 0 = freeze.
- `i_Speed`  in  4  frames per step minus one.
- `i_WrEn`  in  1  buffer write strobe.
- `i_WrAddr`  in  ADDR_W  buffer column address; writes with address >= MSG_LEN are ignored.
- `i_WrCol`  in  8  column data; bit r = row r pixel.
- `o_Data`  out  64  frame image; byte r (`[8*r+:8]`) drives row r.
- `o_Offset`  out  ADDR_W  buffer index of the leftmost displayed column.
- `o_fWrap`  out  1  one-cycle pulse when the offset wraps from MSG_LEN-1 to 0.

## Operation
- Buffer: MSG_LEN x 8 registers. Reset clears it to 0. A write lands at the clock edge where `i_WrEn`=1. A BUILD read of the same address in that cycle returns the old value. Writes are accepted in every state.
- Window mapping: window column k (0 = leftmost) = `buf[(offset+k) mod MSG_LEN]`. `o_Data[8*r + (7-k)]` = bit r of window column k, so the MSB of each row byte is the leftmost pixel.
- Registers: `c_State`, `c_Offset`, `c_K` (3 bits), `c_FCnt` (4 bits), `c_Shadow[63:0]`, `o_Data`, `o_fWrap`.
- The FSM has three states.
  - IDLE
    - `i_Run`=1 -> BUILD, with `c_K`=0.
  - BUILD
    - Each cycle writes window column `c_K` into `c_Shadow` using the mapping above.
    - `c_K` increments each cycle.
    - After `c_K`=7 -> READY.
    - `i_Run` is ignored in this state.
  - READY, on `i_fFrame`:
    - `o_Data` <= `c_Shadow`.
    - If `i_Run`=0 -> IDLE, with `c_FCnt` cleared.
    - Else if `c_FCnt` == `i_Speed`: `c_FCnt` <= 0, `c_Offset` <= (`c_Offset`+1) mod MSG_LEN, -> BUILD. Assert `o_Fwrap` next cycle if the offset wrapped.
    - Else `c_FCnt` <= `c_FCnt`+1 and stay in READY.
  - READY with `i_fFrame`=0: hold.
- `i_fFrame` in IDLE or BUILD is ignored.
- `i_Speed` is sampled only at the READY frame event.
- Offset arithmetic: compare against MSG_LEN-1 and reset to 0; never rely on natural ADDR_W overflow. The window index add uses the same wrap.

## Timing
- Reset values: state IDLE, `o_Data`=0, `o_Offset`=0, `o_fWrap`=0, `c_Shadow`=0, `c_FCnt`=0, buffer all 0.
- Asynchronous reset mid-BUILD or mid-READY aborts immediately to the reset values. No partial window is ever shown.
- `i_Run` rising in IDLE at edge t gives: BUILD for t+1..t+8, READY from t+9.
- `o_Data` changes only at the edge where READY and `i_fFrame`=1. This is the same edge at which the scanner returns to row 0.
- Step latency: a new window is ready 9 cycles after the stepping frame event and is displayed at the next `i_fFrame`. Display therefore lags the offset by one frame.
- `i_fFrame` pulses must be spaced >= 10 cycles apart. The scanner gives 800k cycles.
- `o_Offset` updates at the stepping frame-event edge.
- `o_fWrap` is high exactly one cycle, the cycle after that edge.

## Test plan
- Reset, write `buf[a]`=a for a=0..31, run with `i_Speed`=0, pulse `i_fFrame` once after READY -> `o_Data`=0x0000_0000_000F_3355 and `o_Offset`=1.
- Buffer all 0 except `buf[31]`=0xFF; step to offset 25; the next frame shows 0x0202_0202_0202_0202. At offset 31 it shows 0x8080_8080_8080_8080. The wrap step pulses `o_fWrap` exactly once, and the offset-0 window is 0.
- `i_Speed`=3 with 12 frame pulses -> `o_Offset` goes 0->3, stepping on the 4th, 8th and 12th pulses only.
- Drop `i_Run` during BUILD -> the build completes, the next frame still copies the shadow, then IDLE. Further `i_fFrame` pulses leave `o_Data` and `o_Offset` unchanged.
- Write to an address inside the current window while in READY -> `o_Data` is unchanged until the next BUILD. Write to address 40 -> the buffer is unchanged.
- Assert `i_Rst` low mid-BUILD -> all outputs read 0 asynchronously. After release, `i_Run`=1 restarts from offset 0.

Source files
------------

// File: rtl/dm_scroller.sv
// Column-buffer text scroller for the 8x8 dot-matrix scanner.
// Builds an 8-column window from a message buffer and advances it on frame events.
module dm_scroller #(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_fFrame,
  input  logic              i_Run,
  input  logic [3:0]        i_Speed,
  input  logic              i_WrEn,
  input  logic [ADDR_W-1:0] i_WrAddr,
  input  logic [7:0]        i_WrCol,
  output logic [63:0]       o_Data,
  output logic [ADDR_W-1:0] o_Offset,
  output logic              o_fWrap
);

  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(MSG_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUILD,
    S_READY
  } state_t;

  state_t              r_State;
  logic [ADDR_W-1:0]   r_Offset;
  logic [2:0]          r_K;
  logic [3:0]          r_FCnt;
  logic [63:0]         r_Shadow;
  logic [63:0]         r_Data;
  logic                r_fWrap;
  logic [7:0]          r_Buf [MSG_LEN];

  logic [ADDR_W-1:0]   w_RdIdx;
  logic [7:0]          w_Col;

  // K never exceeds 7 and MSG_LEN is at least 9, so one conditional subtract wraps.
  function automatic logic [ADDR_W-1:0] f_WinIdx(input logic [ADDR_W-1:0] base,
                                                 input logic [2:0]        k);
    logic [ADDR_W:0] sum;
    sum = {1'b0, base} + {{(ADDR_W-2){1'b0}}, k};
    if (sum > {1'b0, LP_LAST}) sum = sum - (ADDR_W+1)'(MSG_LEN);
    return sum[ADDR_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] f_NextOffset(input logic [ADDR_W-1:0] off);
    return (off == LP_LAST) ? '0 : off + 1'b1;
  endfunction

  assign w_RdIdx = f_WinIdx(r_Offset, r_K);

  always_comb begin
    w_Col = '0;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (w_RdIdx == ADDR_W'(i)) w_Col = r_Buf[i];
    end
  end

  // Address decode against real entries only, so out-of-range writes fall away.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      for (int i = 0; i < MSG_LEN; i++) r_Buf[i] <= '0;
    end else begin
      for (int i = 0; i < MSG_LEN; i++) begin
        if (i_WrEn && (i_WrAddr == ADDR_W'(i))) r_Buf[i] <= i_WrCol;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_State  <= S_IDLE;
      r_Offset <= '0;
      r_K      <= '0;
      r_FCnt   <= '0;
      r_Shadow <= '0;
      r_Data   <= '0;
      r_fWrap  <= 1'b0;
    end else begin
      r_fWrap <= 1'b0;
      case (r_State)
        S_IDLE: begin
          if (i_Run) begin
            r_K     <= '0;
            r_State <= S_BUILD;
          end
        end
        S_BUILD: begin
          // Column k lands at bit 7-k of every row byte: MSB is the leftmost pixel.
          for (int r = 0; r < 8; r++) r_Shadow[{3'(r), ~r_K}] <= w_Col[r];
          r_K <= r_K + 3'd1;
          if (r_K == 3'd7) r_State <= S_READY;
        end
        S_READY: begin
          if (i_fFrame) begin
            r_Data <= r_Shadow;
            if (!i_Run) begin
              r_FCnt  <= '0;
              r_State <= S_IDLE;
            end else if (r_FCnt == i_Speed) begin
              r_FCnt   <= '0;
              r_Offset <= f_NextOffset(r_Offset);
              r_fWrap  <= (r_Offset == LP_LAST);
              r_K      <= '0;
              r_State  <= S_BUILD;
            end else begin
              r_FCnt <= r_FCnt + 4'd1;
            end
          end
        end
        default: r_State <= S_IDLE;
      endcase
    end
  end

  assign o_Data   = r_Data;
  assign o_Offset = r_Offset;
  assign o_fWrap  = r_fWrap;

endmodule

// File: tb/tb_dm_scroller.sv
// Directed bench for dm_scroller with a frame-result scoreboard.
module tb_dm_scroller;
  localparam int MSG_LEN = 32;
  localparam int ADDR_W  = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fframe;
  logic              run;
  logic [3:0]        speed;
  logic              wren;
  logic [ADDR_W-1:0] wraddr;
  logic [7:0]        wrcol;
  logic [63:0]       data;
  logic [ADDR_W-1:0] off;
  logic              fwrap;

  always #10 clk = ~clk;

  dm_scroller #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
    .i_Clk   (clk),
    .i_Rst   (rst_n),
    .i_fFrame(fframe),
    .i_Run   (run),
    .i_Speed (speed),
    .i_WrEn  (wren),
    .i_WrAddr(wraddr),
    .i_WrCol (wrcol),
    .o_Data  (data),
    .o_Offset(off),
    .o_fWrap (fwrap)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [7:0]  mdl_buf [MSG_LEN];
  logic [63:0] sh;
  int          cur;
  logic [63:0] q_data [$];
  int          q_off  [$];
  bit          q_wrap [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] win(input int o);
    logic [63:0] w;
    logic [7:0]  c;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      c = mdl_buf[(o + k) % MSG_LEN];
      for (int r = 0; r < 8; r++) w[8*r + 7 - k] = c[r];
    end
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    wraddr = ADDR_W'(a);
    wrcol  = d;
    wren   = 1'b1;
    tick(1);
    wren   = 1'b0;
  endtask

  task automatic frame_check(input string tag, input logic [63:0] ed, input int eo, input bit ew);
    q_data.push_back(ed);
    q_off.push_back(eo);
    q_wrap.push_back(ew);
    fframe = 1'b1;
    tick(1);
    fframe = 1'b0;
    chk({tag, ".data"}, data, q_data.pop_front());
    chk({tag, ".off"}, 64'(off), 64'(q_off.pop_front()));
    chk({tag, ".wrap"}, 64'(fwrap), 64'(q_wrap.pop_front()));
    tick(1);
    chk({tag, ".wrap_after"}, 64'(fwrap), 64'd0);
  endtask

  task automatic step(input string tag);
    int nx;
    nx = (cur + 1) % MSG_LEN;
    frame_check(tag, sh, nx, nx == 0);
    cur = nx;
    sh  = win(cur);
    tick(9);
  endtask

  task automatic hold(input string tag);
    frame_check(tag, sh, cur, 1'b0);
    tick(9);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; fframe = 1'b0; run = 1'b0; speed = 4'd0;
    wren = 1'b0; wraddr = '0; wrcol = '0;
    for (int i = 0; i < MSG_LEN; i++) mdl_buf[i] = '0;
    tick(3);
    chk("reset.data", data, 64'd0);
    chk("reset.off", 64'(off), 64'd0);
    chk("reset.wrap", 64'(fwrap), 64'd0);
    rst_n = 1'b1;
    tick(1);

    // Ramp message, first frame shows offset-0 window
    for (int a = 0; a < MSG_LEN; a++) begin
      wr(a, 8'(a));
      mdl_buf[a] = 8'(a);
    end
    run = 1'b1;
    tick(10);
    chk("pre_frame.data", data, 64'd0);
    cur = 0;
    frame_check("first", 64'h0000_0000_000F_3355, 1, 1'b0);
    cur = 1; sh = win(1);
    tick(9);

    // Write inside the displayed window while READY
    wr(3, 8'hAA);
    mdl_buf[3] = 8'hAA;
    step("inwin_old");
    step("inwin_new");

    // Out-of-range address must not alias into the buffer
    wr(40, 8'hFF);
    step("addr40_a");
    step("addr40_b");

    // Single lit column at the end of the message
    for (int a = 0; a < MSG_LEN - 1; a++) begin
      wr(a, 8'h00);
      mdl_buf[a] = 8'h00;
    end
    wr(31, 8'hFF);
    mdl_buf[31] = 8'hFF;
    while (cur != 25) step("scan_a");
    frame_check("off25", 64'h0202_0202_0202_0202, 26, 1'b0);
    cur = 26; sh = win(26);
    tick(9);
    while (cur != 31) step("scan_b");
    frame_check("off31", 64'h8080_8080_8080_8080, 0, 1'b1);
    cur = 0; sh = win(0);
    tick(9);
    frame_check("off0", 64'h0, 1, 1'b0);
    cur = 1; sh = win(1);
    tick(9);

    // Speed 3: step on every 4th frame event only
    for (int i = 0; i < 16; i++) begin
      wr(i, 8'(i * 3 + 1));
      mdl_buf[i] = 8'(i * 3 + 1);
    end
    speed = 4'd3;
    for (int p = 1; p <= 12; p++) begin
      if (p % 4 == 0) step("speed_step");
      else            hold("speed_hold");
    end

    // Drop run during BUILD
    speed = 4'd0;
    frame_check("drop_step", sh, cur + 1, 1'b0);
    cur = cur + 1;
    run = 1'b0;
    sh  = win(cur);
    tick(9);
    frame_check("drop_copy", sh, cur, 1'b0);
    tick(9);
    frame_check("idle_a", sh, cur, 1'b0);
    tick(9);
    frame_check("idle_b", sh, cur, 1'b0);
    tick(9);

    // Asynchronous reset mid-BUILD
    run = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #2;
    chk("midrst.data", data, 64'd0);
    chk("midrst.off", 64'(off), 64'd0);
    chk("midrst.wrap", 64'(fwrap), 64'd0);
    tick(2);
    run = 1'b0;
    for (int i = 0; i < MSG_LEN; i++) mdl_buf[i] = '0;
    rst_n = 1'b1;
    tick(1);
    for (int a = 0; a < 4; a++) begin
      wr(a, 8'(a));
      mdl_buf[a] = 8'(a);
    end
    run = 1'b1;
    tick(10);
    cur = 0;
    frame_check("restart", 64'h0000_0000_0000_3050, 1, 1'b0);
    tick(9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
